fp16_add_scheduler: RTL and testbench
=====================================

Name: fp16_add_scheduler

Overview:
- Shares one pipelined FP16 adder (align, add, normalize stages) between NUM_REQ requesters, e.g. systolic-array column accumulators.
- Picks one requester per cycle by round-robin and drives the adder operand/start interface.
- Tracks each in-flight operation's owner with a tag pipeline, then steers the adder result back to that requester's output slot with valid/ready backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ADD_LATENCY, 3, cycles from add_start to add_done of the shared adder (1..8).
- ID_W, $clog2(NUM_REQ), width of the requester tag (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_a  in  NUM_REQ*16  FP16 operand A, requester i at [16i+15:16i].
- req_b  in  NUM_REQ*16  FP16 operand B, same packing.
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- add_start  out  1  registered start strobe to adder.
- add_fp1  out  16  registered operand A to adder.
- add_fp2  out  16  registered operand B to adder.
- add_done  in  1  adder result strobe.
- add_result  in  16  adder FP16 result.
- res_valid  out  NUM_REQ  per-requester result valid.
- res_data  out  NUM_REQ*16  per-requester result, same packing.
- res_ready  in  NUM_REQ  per-requester result accept.
- busy  out  1  OR of all pending flags.
- protocol_err  out  1  sticky adder-protocol error.

Behaviour:
- Reset:
  - nRST low clears all of: add_start, add_fp1, add_fp2, res_valid, res_data, pending[], tag pipeline, rr_ptr (to 0), protocol_err.
  - Reset mid-operation discards all in-flight work.
- Eligibility: requester i is eligible when req_valid[i] & ~pending[i]. Each requester has at most one operation outstanding.
- Arbitration:
  - Search starts at rr_ptr, wraps modulo NUM_REQ; the first eligible requester is granted, and req_ready has exactly that one bit high.
  - On a grant to g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
  - At most one grant per cycle.
- Issue:
  - A grant at cycle T sets pending[g] at T+1 and loads add_fp1/add_fp2 from req_a/req_b of g.
  - add_start is 1 for exactly one cycle at T+1. With no grant, add_start = 0 and the operands hold their previous value.
- Tag pipeline:
  - ADD_LATENCY-deep shift register of {valid, id}, loaded alongside add_start and shifted every cycle.
  - The entry at the tail aligns with the cycle the adder asserts add_done, i.e. T+1+ADD_LATENCY.
- Writeback:
  - When the tail entry is valid and add_done = 1: res_data[id] <= add_result and res_valid[id] <= 1, visible at T+2+ADD_LATENCY.
  - Slot overwrite is impossible because pending blocks re-issue.
- Consume:
  - res_valid[i] & res_ready[i] clears res_valid[i] and pending[i] at the next edge.
  - Requester i becomes eligible again the cycle after consumption; no same-cycle reissue.
  - A held result keeps res_data stable until accepted.
- Minimum per-requester turnaround: ADD_LATENCY+3 cycles. Aggregate throughput: one issue per cycle when NUM_REQ >= ADD_LATENCY+3 and results are consumed immediately.
- Protocol errors: protocol_err is set and held until reset in either case below.
  - Tail entry valid but add_done = 0. The operation is lost and pending[id] stays set.
  - add_done = 1 with no valid tail entry. add_result is ignored.
- Simultaneous events: writeback to requester i and consumption by requester j (j != i) in the same cycle are independent and both take effect.
- busy = |pending, registered.

Test Plan:
- Single op: after reset, req_valid[0] = 1, req_a = 0x3C00, req_b = 0x4000 at cycle 0.
  - Response: req_ready[0] = 1 at cycle 0; add_start = 1 with operands 0x3C00/0x4000 at cycle 1.
  - Bench adder returns 0x4200 at cycle 4; res_valid[0] = 1 with res_data[0] = 0x4200 at cycle 5.
  - res_ready[0] = 1 then clears res_valid[0] and busy.
- Full contention: all four req_valid held high, res_ready all 1.
  - Grants 0, 1, 2, 3 on consecutive cycles.
  - Requester 0 is regranted only after its result is consumed; no requester is granted twice while pending.
- Round-robin rotation: rr_ptr = 2 with req_valid = 4'b1010 → grant 3 first, then 1 on the next cycle.
- Backpressure: res_ready[2] = 0 for 10 cycles after its result arrives.
  - res_valid[2] stays 1 and res_data[2] stays stable.
  - req_ready[2] stays 0 despite req_valid[2] = 1; requesters 0, 1, 3 continue issuing and completing.
- Protocol errors:
  - Bench asserts add_done with no op in flight → protocol_err = 1, and it stays 1 until nRST.
  - Bench withholds add_done for an issued op → protocol_err = 1 and pending stays set.
- Reset mid-flight: nRST pulsed low 2 cycles after add_start.
  - All outputs read 0 immediately (asynchronous), and rr_ptr = 0.
  - A fresh request after release completes normally with protocol_err = 0, provided the bench does not return the discarded result.

Source files
------------

// File: rtl/fp16_add_scheduler_if.sv
// -----------------------------------------------------------------------------
// fp16_add_scheduler_if
//   Bundles every non-clock/reset signal of the shared FP16 adder scheduler.
//   There are three groups:
//     requester side : req_valid, req_a, req_b, req_ready
//     adder side     : add_start, add_fp1, add_fp2, add_done, add_result
//     result side    : res_valid, res_data, res_ready, plus busy / protocol_err
//   Per-requester buses are packed with requester i at [16i+15:16i].
//   modport slave  : the scheduler itself.
//   modport master : the environment (requesters, adder, result consumers).
// -----------------------------------------------------------------------------
interface fp16_add_scheduler_if #(
  parameter int NUM_REQ = 4
);
  // requester request channel
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*16-1:0] req_a;
  logic [NUM_REQ*16-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;

  // shared adder operand / result channel
  logic                  add_start;
  logic [15:0]           add_fp1;
  logic [15:0]           add_fp2;
  logic                  add_done;
  logic [15:0]           add_result;

  // per-requester result channel
  logic [NUM_REQ-1:0]    res_valid;
  logic [NUM_REQ*16-1:0] res_data;
  logic [NUM_REQ-1:0]    res_ready;

  // status
  logic                  busy;
  logic                  protocol_err;

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready,
    output add_start, add_fp1, add_fp2,
    input  add_done, add_result,
    output res_valid, res_data,
    input  res_ready,
    output busy, protocol_err
  );

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready,
    input  add_start, add_fp1, add_fp2,
    output add_done, add_result,
    input  res_valid, res_data,
    output res_ready,
    input  busy, protocol_err
  );
endinterface

// File: rtl/fp16_add_scheduler.sv
// -----------------------------------------------------------------------------
// fp16_add_scheduler
//   Time-shares one pipelined FP16 adder between NUM_REQ requesters.
//   Each cycle a round-robin arbiter grants at most one eligible requester.
//   The grant means a valid request with no operation outstanding.
//   The granted operands go to the adder with a one-cycle start strobe.
//   A tag pipeline remembers who owns each in-flight operation.
//   When the adder reports done, the result goes to the owner's result slot.
//   The slot holds the result until that requester accepts it.
//
// Ports
//   clk   : rising-edge clock
//   nRST  : asynchronous active-low reset, discards all in-flight work
//   bus   : fp16_add_scheduler_if.slave, which carries:
//     req_valid/req_a/req_b  in   per-requester operation request
//     req_ready              out  one-hot combinational grant
//     add_start/fp1/fp2      out  registered adder start + operands
//     add_done/add_result    in   adder completion strobe + result
//     res_valid/res_data     out  per-requester held result
//     res_ready              in   per-requester result accept
//     busy                   out  registered OR of pending flags
//     protocol_err           out  sticky: done/tag misalignment seen
//
// Parameters
//   NUM_REQ     : requester count (2..16), must match the interface
//   ADD_LATENCY : add_start -> add_done latency of the adder (1..8)
// -----------------------------------------------------------------------------
module fp16_add_scheduler #(
  parameter  int NUM_REQ     = 4,
  parameter  int ADD_LATENCY = 3,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       nRST,
  fp16_add_scheduler_if.slave        bus
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                   add_start_q;
  logic [15:0]            add_fp1_q;
  logic [15:0]            add_fp2_q;
  logic [ID_W-1:0]        issue_id_q;     // owner of the op currently on add_start
  logic [ID_W-1:0]        rr_ptr_q;
  logic [NUM_REQ-1:0]     pending_q;
  logic [NUM_REQ-1:0]     pending_d;
  logic [NUM_REQ-1:0]     res_valid_q;
  logic [NUM_REQ-1:0]     res_valid_d;
  logic [15:0]            res_data_q [NUM_REQ];
  logic                   busy_q;
  logic                   protocol_err_q;

  logic [ADD_LATENCY-1:0] tag_vld_q;
  logic [ID_W-1:0]        tag_id_q [ADD_LATENCY];

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0]     eligible;
  logic [ID_W-1:0]        cand_id [NUM_REQ];
  logic                   grant_vld;
  logic [ID_W-1:0]        grant_id;
  logic [ID_W-1:0]        rr_next;
  logic [NUM_REQ-1:0]     consume;

  assign eligible = bus.req_valid & ~pending_q;
  assign consume  = res_valid_q & bus.res_ready;

  // cand_id[k] is the requester inspected at search position k.
  // It is rr_ptr + k, wrapped modulo NUM_REQ.
  // NUM_REQ need not be a power of two, so the wrap is an explicit compare.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [ID_W:0] cand_sum;
      assign cand_sum    = {1'b0, rr_ptr_q} + (ID_W+1)'(gi);
      assign cand_id[gi] = (cand_sum >= (ID_W+1)'(NUM_REQ))
                           ? ID_W'(cand_sum - (ID_W+1)'(NUM_REQ))
                           : cand_sum[ID_W-1:0];
    end
  endgenerate

  // The loop runs from the far end back toward rr_ptr.
  // So the eligible requester nearest to rr_ptr is the last to assign, and it wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (eligible[cand_id[k]]) begin
        grant_vld = 1'b1;
        grant_id  = cand_id[k];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant_vld) begin
      bus.req_ready[grant_id] = 1'b1;
    end
  end

  assign rr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  // ---------------------------------------------------------------------------
  // Tag pipeline tail / writeback decode
  // ---------------------------------------------------------------------------
  // Stage 0 is loaded from the registered start strobe.
  // An op started in cycle S therefore reaches the tail in cycle S+ADD_LATENCY.
  // That is the cycle in which the adder raises add_done.
  logic            tail_vld;
  logic [ID_W-1:0] tail_id;
  logic            wb_fire;
  logic            proto_mismatch;

  assign tail_vld       = tag_vld_q[ADD_LATENCY-1];
  assign tail_id        = tag_id_q[ADD_LATENCY-1];
  assign wb_fire        = tail_vld & bus.add_done;
  // There are two error cases:
  //   - an expected result that never arrived
  //   - a result that nobody owns
  assign proto_mismatch = tail_vld ^ bus.add_done;

  // ---------------------------------------------------------------------------
  // Pending / result-valid next state
  // ---------------------------------------------------------------------------
  // Grant, writeback and consume may each touch a different requester in one cycle.
  // They cannot hit the same requester:
  //   - a pending requester is never granted
  //   - a slot is only written while its owner is pending and not yet holding a result
  always_comb begin
    pending_d   = pending_q & ~consume;
    res_valid_d = res_valid_q & ~consume;
    if (grant_vld) begin
      pending_d[grant_id] = 1'b1;
    end
    if (wb_fire) begin
      res_valid_d[tail_id] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue, arbitration pointer, bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      add_start_q    <= 1'b0;
      add_fp1_q      <= '0;
      add_fp2_q      <= '0;
      issue_id_q     <= '0;
      rr_ptr_q       <= '0;
      pending_q      <= '0;
      res_valid_q    <= '0;
      busy_q         <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      add_start_q <= grant_vld;
      if (grant_vld) begin
        add_fp1_q  <= bus.req_a[{grant_id, 4'h0} +: 16];
        add_fp2_q  <= bus.req_b[{grant_id, 4'h0} +: 16];
        issue_id_q <= grant_id;
        rr_ptr_q   <= rr_next;
      end
      pending_q   <= pending_d;
      res_valid_q <= res_valid_d;
      busy_q      <= |pending_d;
      if (proto_mismatch) begin
        protocol_err_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline: {valid, owner id}, shifted every cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      tag_vld_q <= '0;
      for (int k = 0; k < ADD_LATENCY; k++) begin
        tag_id_q[k] <= '0;
      end
    end else begin
      tag_vld_q[0] <= add_start_q;
      tag_id_q[0]  <= issue_id_q;
      for (int k = 1; k < ADD_LATENCY; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-requester result slots
  // ---------------------------------------------------------------------------
  // A slot is only written on writeback to its own id.
  // So a held, unaccepted result stays stable until it is consumed.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
          res_data_q[gi] <= '0;
        end else if (wb_fire && (tail_id == ID_W'(gi))) begin
          res_data_q[gi] <= bus.add_result;
        end
      end
      assign bus.res_data[gi*16 +: 16] = res_data_q[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.add_start    = add_start_q;
  assign bus.add_fp1      = add_fp1_q;
  assign bus.add_fp2      = add_fp2_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.busy         = busy_q;
  assign bus.protocol_err = protocol_err_q;

endmodule

// File: tb/tb_fp16_add_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fp16_add_scheduler
//   Directed bench for fp16_add_scheduler with NUM_REQ=4 and ADD_LATENCY=3.
//   A stub adder returns fixed FP16 sums for the operand pairs used here.
//   Inputs change on the falling edge.
//   Registered outputs are sampled on the falling edge.
//   req_ready is sampled #1 after the inputs change.
// -----------------------------------------------------------------------------
module tb_fp16_add_scheduler;

  localparam int NR  = 4;
  localparam int LAT = 3;

  logic clk;
  logic nRST;
  logic drop_done;
  logic inject_done;

  int n_vec = 0;
  int n_err = 0;

  fp16_add_scheduler_if #(.NUM_REQ(NR)) bus ();

  fp16_add_scheduler #(.NUM_REQ(NR), .ADD_LATENCY(LAT)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Stub adder
  //   Fixed LAT-cycle latency.
  //   Results come from a lookup of hand-computed FP16 sums.
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] fp16_sum(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      {16'h3C00, 16'h4000}: return 16'h4200;   // 1 + 2 = 3
      {16'h3C00, 16'h3C00}: return 16'h4000;   // 1 + 1 = 2
      {16'h4000, 16'h4000}: return 16'h4400;   // 2 + 2 = 4
      {16'h4200, 16'h3C00}: return 16'h4400;   // 3 + 1 = 4
      {16'h3800, 16'h3800}: return 16'h3C00;   // 0.5 + 0.5 = 1
      {16'h4400, 16'h4000}: return 16'h4600;   // 4 + 2 = 6
      default:              return 16'h7E00;
    endcase
  endfunction

  logic [LAT-1:0] ap_v;
  logic [15:0]    ap_d [LAT];

  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      ap_v <= '0;
      for (int k = 0; k < LAT; k++) ap_d[k] <= '0;
    end else begin
      ap_v    <= {ap_v[LAT-2:0], bus.add_start};
      ap_d[0] <= fp16_sum(bus.add_fp1, bus.add_fp2);
      for (int k = 1; k < LAT; k++) ap_d[k] <= ap_d[k-1];
    end
  end

  assign bus.add_done   = (ap_v[LAT-1] & ~drop_done) | inject_done;
  assign bus.add_result = ap_d[LAT-1];

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  function automatic logic [15:0] rd(input int i);
    return bus.res_data[i*16 +: 16];
  endfunction

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[i*16 +: 16] = a;
    bus.req_b[i*16 +: 16] = b;
  endtask

  // Reset ends at a falling edge with nRST released.
  task automatic do_reset();
    nRST          = 1'b0;
    bus.req_valid = '0;
    bus.res_ready = '0;
    drop_done     = 1'b0;
    inject_done   = 1'b0;
    repeat (2) @(negedge clk);
    nRST = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 40; c++) begin
      if (bus.busy === 1'b0) break;
      @(negedge clk);
    end
    chk(tag, bus.busy, 1'b0);
  endtask

  task automatic wait_res(input string tag, input int idx, input logic [15:0] exp);
    for (int c = 0; c < 20; c++) begin
      if (bus.res_valid[idx] === 1'b1) break;
      @(negedge clk);
    end
    chk({tag, "_valid"}, bus.res_valid[idx], 1'b1);
    chk({tag, "_data"}, rd(idx), exp);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [NR-1:0] exp_rdy [7];
  int            done0, done1, done3;

  initial begin
    bus.req_a = '0;
    bus.req_b = '0;

    // ---------------- reset state ----------------
    do_reset();
    chk("rst_add_start", bus.add_start, 1'b0);
    chk("rst_add_fp1", bus.add_fp1, 16'h0);
    chk("rst_add_fp2", bus.add_fp2, 16'h0);
    chk("rst_res_valid", bus.res_valid, 4'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_perr", bus.protocol_err, 1'b0);

    // ---------------- single op ----------------
    set_ops(0, 16'h3C00, 16'h4000);
    bus.req_valid = 4'b0001;
    #1 chk("t1_req_ready_c0", bus.req_ready, 4'b0001);
    @(negedge clk);                                   // cycle 1
    chk("t1_add_start_c1", bus.add_start, 1'b1);
    chk("t1_fp1_c1", bus.add_fp1, 16'h3C00);
    chk("t1_fp2_c1", bus.add_fp2, 16'h4000);
    chk("t1_busy_c1", bus.busy, 1'b1);
    bus.req_valid = '0;
    @(negedge clk);                                   // cycle 2
    chk("t1_add_start_c2", bus.add_start, 1'b0);
    repeat (2) @(negedge clk);                        // cycle 4
    chk("t1_add_done_c4", bus.add_done, 1'b1);
    chk("t1_res_valid_c4", bus.res_valid, 4'b0000);
    @(negedge clk);                                   // cycle 5
    chk("t1_res_valid_c5", bus.res_valid, 4'b0001);
    chk("t1_res_data_c5", rd(0), 16'h4200);
    bus.res_ready = 4'b0001;
    @(negedge clk);                                   // cycle 6
    chk("t1_res_valid_c6", bus.res_valid, 4'b0000);
    chk("t1_busy_c6", bus.busy, 1'b0);
    bus.res_ready = '0;

    // ---------------- full contention ----------------
    do_reset();
    set_ops(0, 16'h3C00, 16'h3C00);   // -> 4000
    set_ops(1, 16'h4000, 16'h4000);   // -> 4400
    set_ops(2, 16'h4200, 16'h3C00);   // -> 4400
    set_ops(3, 16'h3800, 16'h3800);   // -> 3C00
    exp_rdy[0] = 4'b0001; exp_rdy[1] = 4'b0010; exp_rdy[2] = 4'b0100;
    exp_rdy[3] = 4'b1000; exp_rdy[4] = 4'b0000; exp_rdy[5] = 4'b0000;
    exp_rdy[6] = 4'b0001;
    bus.res_ready = 4'b1111;
    bus.req_valid = 4'b1111;
    for (int c = 0; c <= 8; c++) begin
      #1;
      if (c <= 6) chk($sformatf("t2_req_ready_c%0d", c), bus.req_ready, exp_rdy[c]);
      if (c == 5) begin
        chk("t2_res_valid_c5", bus.res_valid, 4'b0001);
        chk("t2_res_data0", rd(0), 16'h4000);
      end
      if (c == 6) begin
        chk("t2_res_valid_c6", bus.res_valid, 4'b0010);
        chk("t2_res_data1", rd(1), 16'h4400);
        bus.req_valid = '0;
      end
      if (c == 7) begin
        chk("t2_res_valid_c7", bus.res_valid, 4'b0100);
        chk("t2_res_data2", rd(2), 16'h4400);
      end
      if (c == 8) begin
        chk("t2_res_valid_c8", bus.res_valid, 4'b1000);
        chk("t2_res_data3", rd(3), 16'h3C00);
      end
      @(negedge clk);
    end
    wait_idle("t2_drain_busy");

    // ---------------- round-robin rotation ----------------
    do_reset();
    bus.res_ready = 4'b1111;
    set_ops(1, 16'h3C00, 16'h3C00);
    set_ops(3, 16'h3800, 16'h3800);
    bus.req_valid = 4'b0010;                          // grant 1 -> rr_ptr = 2
    #1 chk("t3_first_grant1", bus.req_ready, 4'b0010);
    @(negedge clk);
    bus.req_valid = '0;
    wait_idle("t3_idle");
    bus.req_valid = 4'b1010;
    #1 chk("t3_rr2_grant3", bus.req_ready, 4'b1000);
    @(negedge clk);
    #1 chk("t3_then_grant1", bus.req_ready, 4'b0010);
    @(negedge clk);
    bus.req_valid = '0;
    wait_idle("t3_drain_busy");

    // ---------------- backpressure on requester 2 ----------------
    do_reset();
    set_ops(0, 16'h3C00, 16'h3C00);   // -> 4000
    set_ops(1, 16'h4000, 16'h4000);   // -> 4400
    set_ops(2, 16'h4400, 16'h4000);   // -> 4600
    set_ops(3, 16'h3800, 16'h3800);   // -> 3C00
    bus.res_ready = 4'b1011;
    bus.req_valid = 4'b1111;
    wait_res("t4_r2", 2, 16'h4600);
    done0 = 0; done1 = 0; done3 = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("t4_hold_c%0d", c),
          {bus.res_valid[2], bus.req_ready[2], rd(2)}, {1'b1, 1'b0, 16'h4600});
      if (bus.res_valid[0]) begin
        done0++;
        chk("t4_r0_data", rd(0), 16'h4000);
      end
      if (bus.res_valid[1]) begin
        done1++;
        chk("t4_r1_data", rd(1), 16'h4400);
      end
      if (bus.res_valid[3]) begin
        done3++;
        chk("t4_r3_data", rd(3), 16'h3C00);
      end
      @(negedge clk);
    end
    chk("t4_r0_progress", done0 > 0, 1'b1);
    chk("t4_r1_progress", done1 > 0, 1'b1);
    chk("t4_r3_progress", done3 > 0, 1'b1);
    bus.req_valid = '0;
    bus.res_ready = 4'b1111;
    @(negedge clk);
    chk("t4_r2_consumed", bus.res_valid[2], 1'b0);
    wait_idle("t4_drain_busy");

    // ---------------- protocol error: spurious add_done ----------------
    do_reset();
    chk("t5a_perr_clear", bus.protocol_err, 1'b0);
    inject_done = 1'b1;
    @(negedge clk);
    inject_done = 1'b0;
    chk("t5a_perr_set", bus.protocol_err, 1'b1);
    chk("t5a_no_result", bus.res_valid, 4'b0000);
    repeat (5) @(negedge clk);
    chk("t5a_perr_sticky", bus.protocol_err, 1'b1);
    do_reset();
    chk("t5a_perr_rst", bus.protocol_err, 1'b0);

    // ---------------- protocol error: withheld add_done ----------------
    drop_done = 1'b1;
    set_ops(0, 16'h3C00, 16'h4000);
    bus.res_ready = 4'b1111;
    bus.req_valid = 4'b0001;
    repeat (4) @(negedge clk);                        // cycle 4
    chk("t5b_perr_c4", bus.protocol_err, 1'b0);
    @(negedge clk);                                   // cycle 5
    chk("t5b_perr_c5", bus.protocol_err, 1'b1);
    chk("t5b_no_result", bus.res_valid, 4'b0000);
    repeat (5) @(negedge clk);
    #1;
    chk("t5b_busy_held", bus.busy, 1'b1);
    chk("t5b_no_regrant", bus.req_ready, 4'b0000);
    bus.req_valid = '0;
    drop_done = 1'b0;

    // ---------------- reset mid-flight ----------------
    do_reset();
    set_ops(1, 16'h4000, 16'h4000);   // -> 4400
    set_ops(3, 16'h3800, 16'h3800);
    bus.req_valid = 4'b0010;
    @(negedge clk);                                   // cycle 1
    bus.req_valid = '0;
    chk("t6_add_start", bus.add_start, 1'b1);
    repeat (2) @(negedge clk);                        // cycle 3
    nRST = 1'b0;
    #1;
    chk("t6_async_fp1", bus.add_fp1, 16'h0);
    chk("t6_async_fp2", bus.add_fp2, 16'h0);
    chk("t6_async_start", bus.add_start, 1'b0);
    chk("t6_async_busy", bus.busy, 1'b0);
    chk("t6_async_resv", bus.res_valid, 4'b0000);
    chk("t6_async_perr", bus.protocol_err, 1'b0);
    @(negedge clk);
    nRST = 1'b1;
    bus.res_ready = 4'b1111;
    bus.req_valid = 4'b1010;
    #1 chk("t6_rr_reset_grant1", bus.req_ready, 4'b0010);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    wait_res("t6_fresh", 1, 16'h4400);
    chk("t6_perr_clean", bus.protocol_err, 1'b0);
    wait_idle("t6_drain_busy");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
